// File: rtl/tone_scheduler.sv
// Tone scheduler: mixes background music and sound effects onto one tone generator.
// Optional TONE_SCHED_SFX_QUEUE_EN adds a one-deep pending effect slot.
module tone_scheduler #(
  parameter int unsigned SFX_STEP_CYCLES = 6250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bgm_enable,
  input  logic [4:0]  bgm_note,
  input  logic        sfx_req,
  input  logic [1:0]  sfx_id,
  output logic        sfx_ack,
  output logic        sfx_busy,
  output logic [13:0] tone_origin,
  output logic        tone_mute,
  output logic        tone_load
);

`ifdef TONE_SCHED_SFX_QUEUE_EN
  localparam bit QUEUE_EN = 1'b1;
`else
  localparam bit QUEUE_EN = 1'b0;
`endif

  localparam logic [22:0] STEP_RELOAD = 23'(SFX_STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BGM,
    SFX
  } state_e;

  // Half-period reload per note; zero marks a rest (muted).
  function automatic logic [13:0] note_origin(input logic [4:0] n);
    logic [13:0] o;
    case (n)
      5'd1:    o = 14'd4916;
      5'd2:    o = 14'd6168;
      5'd3:    o = 14'd7281;
      5'd4:    o = 14'd8037;
      5'd5:    o = 14'd8730;
      5'd6:    o = 14'd9565;
      5'd7:    o = 14'd10129;
      5'd8:    o = 14'd10647;
      5'd9:    o = 14'd11273;
      5'd10:   o = 14'd11831;
      5'd11:   o = 14'd12209;
      5'd12:   o = 14'd12556;
      5'd13:   o = 14'd12908;
      5'd14:   o = 14'd13227;
      5'd15:   o = 14'd13516;
      5'd16:   o = 14'd13829;
      5'd17:   o = 14'd14108;
      5'd18:   o = 14'd14356;
      5'd19:   o = 14'd14577;
      5'd20:   o = 14'd14774;
      5'd21:   o = 14'd14950;
      default: o = 14'd0;
    endcase
    return o;
  endfunction

  // Four-step note sequence of each effect.
  function automatic logic [4:0] fx_note(input logic [1:0] id,
                                         input logic [1:0] step);
    logic [4:0] n;
    case ({id, step})
      4'h0: n = 5'd15;
      4'h1: n = 5'd17;
      4'h2: n = 5'd17;
      4'h3: n = 5'd0;
      4'h4: n = 5'd3;
      4'h5: n = 5'd1;
      4'h6: n = 5'd1;
      4'h7: n = 5'd0;
      4'h8: n = 5'd8;
      4'h9: n = 5'd10;
      4'hA: n = 5'd12;
      4'hB: n = 5'd15;
      4'hC: n = 5'd12;
      4'hD: n = 5'd8;
      4'hE: n = 5'd5;
      default: n = 5'd1;
    endcase
    return n;
  endfunction

  state_e      state_q;
  logic [13:0] origin_q;
  logic        mute_q;
  logic        load_q;
  logic        ack_q;
  logic        busy_q;
  logic [4:0]  note_q;
  logic [22:0] cnt_q;
  logic [1:0]  step_q;
  logic [1:0]  id_q;
  logic        pend_q;
  logic [1:0]  pend_id_q;

  logic        take;
  logic        fx_last;
  logic [13:0] bgm_org;
  logic [13:0] req_org;
  logic [13:0] pend_org;
  logic [13:0] step_org;

  // The cycle right after an ack still sees the acked request; skip it.
  assign take     = sfx_req && !ack_q;
  assign fx_last  = (cnt_q == '0) && (step_q == 2'd3);
  assign bgm_org  = note_origin(bgm_note);
  assign req_org  = note_origin(fx_note(sfx_id, 2'd0));
  assign pend_org = note_origin(fx_note(pend_id_q, 2'd0));
  assign step_org = note_origin(fx_note(id_q, step_q + 2'd1));

  // Mode FSM with registered tone outputs and handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      origin_q  <= '0;
      mute_q    <= 1'b1;
      load_q    <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      note_q    <= '0;
      cnt_q     <= '0;
      step_q    <= '0;
      id_q      <= '0;
      pend_q    <= 1'b0;
      pend_id_q <= '0;
    end else begin
      load_q <= 1'b0;
      ack_q  <= 1'b0;
      unique case (state_q)
        SFX: begin
          if (fx_last) begin
            if (QUEUE_EN && pend_q) begin
              pend_q   <= 1'b0;
              id_q     <= pend_id_q;
              step_q   <= '0;
              cnt_q    <= STEP_RELOAD;
              origin_q <= pend_org;
              mute_q   <= (pend_org == '0);
              load_q   <= 1'b1;
            end else if (QUEUE_EN && take) begin
              ack_q    <= 1'b1;
              id_q     <= sfx_id;
              step_q   <= '0;
              cnt_q    <= STEP_RELOAD;
              origin_q <= req_org;
              mute_q   <= (req_org == '0);
              load_q   <= 1'b1;
            end else begin
              busy_q <= 1'b0;
              load_q <= 1'b1;
              if (bgm_enable) begin
                state_q  <= BGM;
                note_q   <= bgm_note;
                origin_q <= bgm_org;
                mute_q   <= (bgm_org == '0);
              end else begin
                state_q  <= IDLE;
                origin_q <= '0;
                mute_q   <= 1'b1;
              end
            end
          end else begin
            if (cnt_q == '0) begin
              step_q   <= step_q + 2'd1;
              cnt_q    <= STEP_RELOAD;
              origin_q <= step_org;
              mute_q   <= (step_org == '0);
              load_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 23'd1;
            end
            if (QUEUE_EN && take && !pend_q) begin
              pend_q    <= 1'b1;
              pend_id_q <= sfx_id;
              ack_q     <= 1'b1;
            end
          end
        end
        BGM: begin
          if (take) begin
            state_q  <= SFX;
            busy_q   <= 1'b1;
            ack_q    <= 1'b1;
            id_q     <= sfx_id;
            step_q   <= '0;
            cnt_q    <= STEP_RELOAD;
            origin_q <= req_org;
            mute_q   <= (req_org == '0);
            load_q   <= 1'b1;
          end else if (!bgm_enable) begin
            state_q  <= IDLE;
            origin_q <= '0;
            mute_q   <= 1'b1;
            load_q   <= 1'b1;
          end else if (bgm_note != note_q) begin
            note_q   <= bgm_note;
            origin_q <= bgm_org;
            mute_q   <= (bgm_org == '0);
            load_q   <= 1'b1;
          end
        end
        default: begin
          if (take) begin
            state_q  <= SFX;
            busy_q   <= 1'b1;
            ack_q    <= 1'b1;
            id_q     <= sfx_id;
            step_q   <= '0;
            cnt_q    <= STEP_RELOAD;
            origin_q <= req_org;
            mute_q   <= (req_org == '0);
            load_q   <= 1'b1;
          end else if (bgm_enable) begin
            state_q  <= BGM;
            note_q   <= bgm_note;
            origin_q <= bgm_org;
            mute_q   <= (bgm_org == '0);
            load_q   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign sfx_ack     = ack_q;
  assign sfx_busy    = busy_q;
  assign tone_origin = origin_q;
  assign tone_mute   = mute_q;
  assign tone_load   = load_q;

endmodule
